// File: rtl/pipe_control_unit.sv
// Pipelined control unit for the KGP-RISC core: decodes IF/ID into a control word,
// carries it through EX, MEM and WB, and raises load-use stall, flush and pcsrc.
module pipe_control_unit #(
  parameter int ALUF_W    = 4,
  parameter int REG_AW    = 5,
  parameter int WB_DELAY  = 1,
  parameter int HAZARD_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              branch_condition,
  output logic              stall,
  output logic              pcsrc,
  output logic              ex_alusrc,
  output logic [ALUF_W-1:0] ex_alufunc,
  output logic [1:0]        ex_brtype,
  output logic              ex_illegal,
  output logic              mem_readdmem,
  output logic              mem_writedmem,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_AW-1:0] wb_dst
);

  typedef struct packed {
    logic              alusrc;
    logic [ALUF_W-1:0] alufunc;
    logic [1:0]        brtype;
    logic              branch;
    logic              jump;
    logic              illegal;
    logic              readdmem;
    logic              writedmem;
    logic              regwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] dst;
  } ctrl_t;

  logic [1:0]        op_class;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;

  assign op_class = instr[31:30];
  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign rs       = instr[21 +: REG_AW];
  assign rt       = instr[16 +: REG_AW];
  assign rd       = instr[11 +: REG_AW];

  ctrl_t      dec_ctrl;
  logic       dec_valid;
  logic       dec_uses_rt;
  logic [3:0] alu4;

  always_comb begin
    dec_ctrl    = '0;
    dec_valid   = (instr != 32'b0);
    dec_uses_rt = 1'b0;
    alu4        = 4'd0;
    case (op_class)
      2'b00: begin
        dec_uses_rt = 1'b1;
        if (funct >= 6'd1 && funct <= 6'd10) begin
          alu4              = funct[3:0] - 4'd1;
          dec_ctrl.alufunc  = ALUF_W'(alu4);
          dec_ctrl.regwrite = 1'b1;
          dec_ctrl.dst      = rd;
        end else begin
          dec_ctrl.illegal = 1'b1;
        end
      end
      2'b01: begin
        if (opcode <= 6'h1A) begin
          // MOVE (0x1A) uses function 0; the rest map by their low nibble
          alu4              = (opcode == 6'h1A) ? 4'd0 : opcode[3:0];
          dec_ctrl.alufunc  = ALUF_W'(alu4);
          dec_ctrl.alusrc   = 1'b1;
          dec_ctrl.regwrite = 1'b1;
          dec_ctrl.dst      = rt;
        end else begin
          dec_ctrl.illegal = 1'b1;
        end
      end
      2'b10: begin
        if (opcode == 6'h21) begin
          dec_ctrl.alusrc   = 1'b1;
          dec_ctrl.readdmem = 1'b1;
          dec_ctrl.regwrite = 1'b1;
          dec_ctrl.memtoreg = 1'b1;
          dec_ctrl.dst      = rt;
        end else if (opcode == 6'h22) begin
          dec_uses_rt        = 1'b1;
          dec_ctrl.alusrc    = 1'b1;
          dec_ctrl.writedmem = 1'b1;
        end else begin
          dec_ctrl.illegal = 1'b1;
        end
      end
      default: begin
        if (opcode >= 6'h30 && opcode <= 6'h33) begin
          dec_uses_rt     = 1'b1;
          dec_ctrl.branch = 1'b1;
          dec_ctrl.brtype = opcode[1:0];
        end else if (opcode == 6'h34) begin
          dec_ctrl.jump = 1'b1;
        end else begin
          dec_ctrl.illegal = 1'b1;
        end
      end
    endcase
  end

  ctrl_t ex_ctrl_reg;
  logic  ex_valid_reg;
  ctrl_t mem_ctrl_reg;
  logic  mem_valid_reg;
  ctrl_t wb_ctrl_reg  [WB_DELAY];
  logic  wb_valid_reg [WB_DELAY];

  logic load_use;

  assign pcsrc = ex_valid_reg &
                 (ex_ctrl_reg.jump | (ex_ctrl_reg.branch & branch_condition));

  always_comb begin
    load_use = 1'b0;
    if (HAZARD_EN != 0 && ex_valid_reg && ex_ctrl_reg.readdmem &&
        ex_ctrl_reg.dst != '0) begin
      load_use = (ex_ctrl_reg.dst == rs) ||
                 (dec_uses_rt && ex_ctrl_reg.dst == rt);
    end
  end

  // A taken branch/jump flushes the decode slot, so the stall is moot then
  assign stall = load_use & ~pcsrc;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl_reg   <= '0;
      ex_valid_reg  <= 1'b0;
      mem_ctrl_reg  <= '0;
      mem_valid_reg <= 1'b0;
    end else begin
      if (dec_valid && !pcsrc && !stall) begin
        ex_ctrl_reg  <= dec_ctrl;
        ex_valid_reg <= 1'b1;
      end else begin
        ex_ctrl_reg  <= '0;
        ex_valid_reg <= 1'b0;
      end
      mem_ctrl_reg  <= ex_valid_reg ? ex_ctrl_reg : '0;
      mem_valid_reg <= ex_valid_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WB_DELAY; gi++) begin : g_wb
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) begin
            wb_ctrl_reg[gi]  <= '0;
            wb_valid_reg[gi] <= 1'b0;
          end else begin
            wb_ctrl_reg[gi]  <= mem_valid_reg ? mem_ctrl_reg : '0;
            wb_valid_reg[gi] <= mem_valid_reg;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (reset) begin
            wb_ctrl_reg[gi]  <= '0;
            wb_valid_reg[gi] <= 1'b0;
          end else begin
            wb_ctrl_reg[gi]  <= wb_ctrl_reg[gi-1];
            wb_valid_reg[gi] <= wb_valid_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  ctrl_t wb_ctrl;
  logic  wb_valid;

  assign wb_ctrl  = wb_ctrl_reg[WB_DELAY-1];
  assign wb_valid = wb_valid_reg[WB_DELAY-1];

  assign ex_alusrc     = ex_valid_reg & ex_ctrl_reg.alusrc;
  assign ex_alufunc    = ex_valid_reg ? ex_ctrl_reg.alufunc : '0;
  assign ex_brtype     = ex_valid_reg ? ex_ctrl_reg.brtype : 2'b00;
  assign ex_illegal    = ex_valid_reg & ex_ctrl_reg.illegal;
  assign mem_readdmem  = mem_valid_reg & mem_ctrl_reg.readdmem;
  assign mem_writedmem = mem_valid_reg & mem_ctrl_reg.writedmem;
  assign wb_regwrite   = wb_valid & wb_ctrl.regwrite;
  assign wb_memtoreg   = wb_valid & wb_ctrl.memtoreg;
  assign wb_dst        = (wb_valid && wb_ctrl.regwrite) ? wb_ctrl.dst : '0;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: instance a uses defaults, instance b uses
// WB_DELAY=3, ALUF_W=6 and no hazard detection, both driven by the same stimulus.
module tb_pipe_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        branch_condition;

  logic       a_stall, a_pcsrc, a_ex_alusrc, a_ex_illegal;
  logic [3:0] a_ex_alufunc;
  logic [1:0] a_ex_brtype;
  logic       a_mem_readdmem, a_mem_writedmem, a_wb_regwrite, a_wb_memtoreg;
  logic [4:0] a_wb_dst;

  logic       b_stall, b_pcsrc, b_ex_alusrc, b_ex_illegal;
  logic [5:0] b_ex_alufunc;
  logic [1:0] b_ex_brtype;
  logic       b_mem_readdmem, b_mem_writedmem, b_wb_regwrite, b_wb_memtoreg;
  logic [4:0] b_wb_dst;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] ADD    = 32'h0022_1801; // rd=3, rs=1, rt=2
  localparam logic [31:0] SRL    = 32'h0022_180A;
  localparam logic [31:0] ADD2   = 32'h00A6_3801; // rd=7, rs=5, rt=6
  localparam logic [31:0] LD     = 32'h8424_0000; // r4 <- mem[r1]
  localparam logic [31:0] LD0    = 32'h8420_0000; // dst r0
  localparam logic [31:0] ADDI   = 32'h4085_0000; // rs=4, rt=5
  localparam logic [31:0] ADDI_W = 32'h40A4_0000; // rs=5, writes r4
  localparam logic [31:0] ADDR0  = 32'h0000_1801; // rs=0, rt=0
  localparam logic [31:0] ST     = 32'h88A4_0000;
  localparam logic [31:0] BR     = 32'hD000_0000;
  localparam logic [31:0] BEQ    = 32'hC800_0000;
  localparam logic [31:0] ILL    = 32'hFC00_0000;

  always #5 clk = ~clk;

  pipe_control_unit u_a (
    .clk(clk), .reset(reset), .instr(instr), .branch_condition(branch_condition),
    .stall(a_stall), .pcsrc(a_pcsrc), .ex_alusrc(a_ex_alusrc),
    .ex_alufunc(a_ex_alufunc), .ex_brtype(a_ex_brtype), .ex_illegal(a_ex_illegal),
    .mem_readdmem(a_mem_readdmem), .mem_writedmem(a_mem_writedmem),
    .wb_regwrite(a_wb_regwrite), .wb_memtoreg(a_wb_memtoreg), .wb_dst(a_wb_dst)
  );

  pipe_control_unit #(.ALUF_W(6), .REG_AW(5), .WB_DELAY(3), .HAZARD_EN(0)) u_b (
    .clk(clk), .reset(reset), .instr(instr), .branch_condition(branch_condition),
    .stall(b_stall), .pcsrc(b_pcsrc), .ex_alusrc(b_ex_alusrc),
    .ex_alufunc(b_ex_alufunc), .ex_brtype(b_ex_brtype), .ex_illegal(b_ex_illegal),
    .mem_readdmem(b_mem_readdmem), .mem_writedmem(b_mem_writedmem),
    .wb_regwrite(b_wb_regwrite), .wb_memtoreg(b_wb_memtoreg), .wb_dst(b_wb_dst)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] a_all();
    return {13'd0, a_stall, a_pcsrc, a_ex_alusrc, a_ex_alufunc, a_ex_brtype,
            a_ex_illegal, a_mem_readdmem, a_mem_writedmem, a_wb_regwrite,
            a_wb_memtoreg, a_wb_dst};
  endfunction

  function automatic logic [31:0] b_all();
    return {11'd0, b_stall, b_pcsrc, b_ex_alusrc, b_ex_alufunc, b_ex_brtype,
            b_ex_illegal, b_mem_readdmem, b_mem_writedmem, b_wb_regwrite,
            b_wb_memtoreg, b_wb_dst};
  endfunction

  initial begin
    reset = 1'b1;
    instr = 32'b0;
    branch_condition = 1'b0;
    tick();
    chk("reset_a_all", a_all(), 32'd0);
    chk("reset_b_all", b_all(), 32'd0);
    reset = 1'b0;

    // ADD: EX after edge 1, WB after edge 3 (a) and edge 5 (b)
    instr = ADD;
    tick();
    chk("add_ex_alufunc", a_ex_alufunc, 32'd0);
    chk("add_ex_alusrc", a_ex_alusrc, 32'd0);
    chk("add_ex_illegal", a_ex_illegal, 32'd0);
    instr = 32'b0;
    tick();
    chk("add_mem_idle", {a_mem_readdmem, a_mem_writedmem}, 32'd0);
    tick();
    chk("add_wb_regwrite", a_wb_regwrite, 32'd1);
    chk("add_wb_dst", a_wb_dst, 32'd3);
    chk("add_wb_memtoreg", a_wb_memtoreg, 32'd0);
    chk("add_b_wb_early", b_wb_regwrite, 32'd0);
    tick();
    chk("add_wb_after", {a_wb_regwrite, a_wb_dst}, 32'd0);
    tick();
    chk("add_b_wb_regwrite", b_wb_regwrite, 32'd1);
    chk("add_b_wb_dst", b_wb_dst, 32'd3);
    tick();

    // SRL: funct 10 -> function 9, zero-filled in the wider instance
    instr = SRL;
    tick();
    chk("srl_a_alufunc", a_ex_alufunc, 32'd9);
    chk("srl_b_alufunc", b_ex_alufunc, 32'd9);
    instr = 32'b0;
    tick(); tick(); tick(); tick();

    // Load-use: LD r4 then ADDI using r4 as rs
    instr = LD;
    tick();
    chk("ld_ex_alusrc", a_ex_alusrc, 32'd1);
    instr = ADDI;
    #1;
    chk("lu_stall", a_stall, 32'd1);
    chk("lu_pcsrc", a_pcsrc, 32'd0);
    chk("lu_b_nostall", b_stall, 32'd0);
    tick();
    chk("lu_stall_drop", a_stall, 32'd0);
    chk("lu_bubble", a_ex_alusrc, 32'd0);
    chk("lu_mem_read", a_mem_readdmem, 32'd1);
    tick();
    chk("lu_addi_alusrc", a_ex_alusrc, 32'd1);
    chk("lu_addi_alufunc", a_ex_alufunc, 32'd0);
    chk("lu_ld_wb_regwrite", a_wb_regwrite, 32'd1);
    chk("lu_ld_wb_memtoreg", a_wb_memtoreg, 32'd1);
    chk("lu_ld_wb_dst", a_wb_dst, 32'd4);
    instr = 32'b0;
    tick(); tick(); tick(); tick();

    // No stall: I-type rt is a destination, and an LD to r0 never stalls
    instr = LD;
    tick();
    instr = ADDI_W;
    #1;
    chk("nolu_itype_rt", a_stall, 32'd0);
    instr = 32'b0;
    tick();
    instr = LD0;
    tick();
    instr = ADDR0;
    #1;
    chk("nolu_r0", a_stall, 32'd0);
    instr = 32'b0;
    tick(); tick(); tick(); tick();

    // ST: alusrc in EX, writedmem in MEM, no write-back
    instr = ST;
    tick();
    chk("st_ex_alusrc", a_ex_alusrc, 32'd1);
    instr = 32'b0;
    tick();
    chk("st_mem_write", a_mem_writedmem, 32'd1);
    tick();
    chk("st_wb_regwrite", a_wb_regwrite, 32'd0);
    tick(); tick(); tick();

    // BR then ADD: the ADD is squashed
    instr = BR;
    tick();
    instr = ADD;
    #1;
    chk("br_pcsrc", a_pcsrc, 32'd1);
    tick();
    chk("br_flush_ex", {a_ex_alusrc, a_ex_alufunc, a_ex_illegal, a_pcsrc}, 32'd0);
    instr = 32'b0;
    tick(); tick();
    chk("br_no_wb", a_wb_regwrite, 32'd0);
    tick();

    // BEQ: not taken, then taken
    instr = BEQ;
    branch_condition = 1'b0;
    tick();
    chk("beq_nt_pcsrc", a_pcsrc, 32'd0);
    chk("beq_brtype", a_ex_brtype, 32'd2);
    branch_condition = 1'b1;
    #1;
    chk("beq_t_pcsrc", a_pcsrc, 32'd1);
    instr = 32'b0;
    tick();
    branch_condition = 1'b0;
    tick(); tick(); tick();

    // Illegal opcode 0x3F
    instr = ILL;
    tick();
    chk("ill_flag", a_ex_illegal, 32'd1);
    chk("ill_ctrl", {a_ex_alusrc, a_ex_alufunc, a_ex_brtype, a_pcsrc, a_stall}, 32'd0);
    instr = 32'b0;
    tick();
    chk("ill_mem", {a_mem_readdmem, a_mem_writedmem}, 32'd0);
    tick();
    chk("ill_wb", {a_wb_regwrite, a_wb_dst}, 32'd0);
    tick(); tick();

    // BR in EX while decode holds an r4 consumer: flush, no stall
    instr = BR;
    tick();
    instr = ADDI;
    #1;
    chk("flush_pcsrc", a_pcsrc, 32'd1);
    chk("flush_nostall", a_stall, 32'd0);
    instr = 32'b0;
    tick(); tick(); tick(); tick();

    // Reset with three instructions in flight
    instr = LD;
    tick();
    instr = ADD;
    tick();
    instr = ADD2;
    tick();
    reset = 1'b1;
    instr = ADDI;
    tick();
    chk("rst_mid_a_all", a_all(), 32'd0);
    chk("rst_mid_b_all", b_all(), 32'd0);
    reset = 1'b0;
    instr = 32'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_wb_a", a_wb_regwrite, 32'd0);
      chk("rst_no_wb_b", b_wb_regwrite, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
